// File: rtl/ctrl_pipe_pkg.sv
// Shared types and helpers for the control-word pipeline and its multi-cycle sequencer.
package ctrl_pipe_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mc_state_t;

    localparam int unsigned STG_E = 0;
    localparam int unsigned STG_M = 1;
    localparam int unsigned STG_W = 2;

    // Sequencer counter width; never below one bit.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/ctrl_pipe_stage.sv
// One pipeline stage: control word plus valid with flush > hold > bubble > load priority.
module ctrl_pipe_stage
    import ctrl_pipe_pkg::*;
#(
    parameter int unsigned      WIDTH    = 16,
    parameter logic [WIDTH-1:0] CLR_MASK = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] up_ctrl_i,
    input  logic             up_valid_i,
    input  logic             up_hold_i,
    input  logic             hold_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] ctrl_o,
    output logic             valid_o
);

    logic [WIDTH-1:0] ctrl_q, ctrl_d;
    logic             valid_q, valid_d;

    always_comb begin
        ctrl_d  = ctrl_q;
        valid_d = valid_q;
        if (flush_i || (!hold_i && up_hold_i)) begin
            // Flush and bubble both clear masked fields and pass the rest through.
            ctrl_d  = up_ctrl_i & ~CLR_MASK;
            valid_d = 1'b0;
        end else if (!hold_i) begin
            ctrl_d  = up_ctrl_i;
            valid_d = up_valid_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ctrl_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
        end
    end

    assign ctrl_o  = ctrl_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/ctrl_pipe.sv
// Control-word pipeline with per-stage stall/flush and a multi-cycle occupancy sequencer.
module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int unsigned      WIDTH     = 16,
    parameter int unsigned      STAGES    = 3,
    parameter logic [WIDTH-1:0] CLR_MASK  = '1,
    parameter int unsigned      MC_BIT    = 0,
    parameter int unsigned      MC_STAGE  = 0,
    parameter int unsigned      MC_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          ctrl_d,
    input  logic                      valid_d,
    input  logic [STAGES-1:0]         stall,
    input  logic [STAGES-1:0]         flush,
    output logic [STAGES*WIDTH-1:0]   ctrl_q,
    output logic [STAGES-1:0]         valid_q,
    output logic                      mc_stall_req,
    output logic                      mc_busy
);

    localparam int unsigned CNT_W    = cnt_width(MC_CYCLES);
    localparam int unsigned CNT_INIT = (MC_CYCLES > 2) ? MC_CYCLES - 3 : 0;

    logic [WIDTH-1:0]  stg_ctrl [STAGES];
    logic [STAGES-1:0] stg_valid;
    logic [STAGES-1:0] hold;

    mc_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              trigger;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        if (i <= MC_STAGE) begin : g_mc_hold
            assign hold[i] = stall[i] | mc_stall_req;
        end else begin : g_ext_hold
            assign hold[i] = stall[i];
        end

        if (i == 0) begin : g_first
            ctrl_pipe_stage #(.WIDTH(WIDTH), .CLR_MASK(CLR_MASK)) u_stage (
                .clk        (clk),
                .rst        (rst),
                .up_ctrl_i  (ctrl_d),
                .up_valid_i (valid_d),
                .up_hold_i  (1'b0),
                .hold_i     (hold[i]),
                .flush_i    (flush[i]),
                .ctrl_o     (stg_ctrl[i]),
                .valid_o    (stg_valid[i])
            );
        end else begin : g_rest
            ctrl_pipe_stage #(.WIDTH(WIDTH), .CLR_MASK(CLR_MASK)) u_stage (
                .clk        (clk),
                .rst        (rst),
                .up_ctrl_i  (stg_ctrl[i-1]),
                .up_valid_i (stg_valid[i-1]),
                .up_hold_i  (hold[i-1]),
                .hold_i     (hold[i]),
                .flush_i    (flush[i]),
                .ctrl_o     (stg_ctrl[i]),
                .valid_o    (stg_valid[i])
            );
        end

        assign ctrl_q[i*WIDTH +: WIDTH] = stg_ctrl[i];
    end

    assign valid_q = stg_valid;
    assign trigger = stg_valid[MC_STAGE] & stg_ctrl[MC_STAGE][MC_BIT];

    // Sequencer next state; the stall request depends on registers only, never on stall/flush.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mc_stall_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    mc_stall_req = 1'b1;
                    if (MC_CYCLES == 2) begin
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_W'(CNT_INIT);
                    end
                end
            end
            BUSY: begin
                mc_stall_req = 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                // Request is low here, so the stage hold reduces to the external stall.
                if (!stall[MC_STAGE]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (flush[MC_STAGE]) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mc_busy = (state_q != IDLE);

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: two instances (4-cycle and 2-cycle sequencer), directed vectors.
module tb_ctrl_pipe;
    import ctrl_pipe_pkg::*;

    localparam int K_CTRL  = 0;
    localparam int K_VALID = 1;
    localparam int K_REQ   = 2;
    localparam int K_BUSY  = 3;

    typedef struct {
        int          cyc;
        bit          dut;
        int          kind;
        int          stg;
        logic [15:0] exp;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a_ctrl_d, b_ctrl_d;
    logic        a_valid_d, b_valid_d;
    logic [2:0]  a_stall, a_flush, b_stall, b_flush;
    logic [47:0] a_ctrl_q, b_ctrl_q;
    logic [2:0]  a_valid_q, b_valid_q;
    logic        a_req, a_busy, b_req, b_busy;

    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ctrl_pipe #(
        .WIDTH(16), .STAGES(3), .CLR_MASK(16'h00FF),
        .MC_BIT(14), .MC_STAGE(0), .MC_CYCLES(4)
    ) dut_a (
        .clk(clk), .rst(rst), .ctrl_d(a_ctrl_d), .valid_d(a_valid_d),
        .stall(a_stall), .flush(a_flush), .ctrl_q(a_ctrl_q), .valid_q(a_valid_q),
        .mc_stall_req(a_req), .mc_busy(a_busy)
    );

    ctrl_pipe #(
        .WIDTH(16), .STAGES(3), .CLR_MASK(16'h00FF),
        .MC_BIT(14), .MC_STAGE(0), .MC_CYCLES(2)
    ) dut_b (
        .clk(clk), .rst(rst), .ctrl_d(b_ctrl_d), .valid_d(b_valid_d),
        .stall(b_stall), .flush(b_flush), .ctrl_q(b_ctrl_q), .valid_q(b_valid_q),
        .mc_stall_req(b_req), .mc_busy(b_busy)
    );

    function automatic logic [15:0] sample(input bit d, input int kind, input int stg);
        logic [15:0] v;
        case (kind)
            K_CTRL:  v = d ? b_ctrl_q[stg*16 +: 16] : a_ctrl_q[stg*16 +: 16];
            K_VALID: v = {13'b0, (d ? b_valid_q : a_valid_q)};
            K_REQ:   v = {15'b0, (d ? b_req : a_req)};
            default: v = {15'b0, (d ? b_busy : a_busy)};
        endcase
        return v;
    endfunction

    // Monitor: each cycle, compare every expectation due in that cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                logic [15:0] act;
                act = sample(sb[i].dut, sb[i].kind, sb[i].stg);
                n_total++;
                if (act === sb[i].exp) n_pass++;
                else $display("FAIL %s dut=%0d cyc=%0d got=%h exp=%h",
                              sb[i].name, sb[i].dut, cyc, act, sb[i].exp);
                sb.delete(i);
            end
        end
    end

    task automatic sb_push(input int c, input bit d, input int k, input int s,
                           input logic [15:0] e, input string n);
        exp_t x;
        x.cyc = c; x.dut = d; x.kind = k; x.stg = s; x.exp = e; x.name = n;
        sb.push_back(x);
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rand_inputs();
        a_ctrl_d = 16'($urandom); a_valid_d = 1'($urandom);
        a_stall  = 3'($urandom);  a_flush   = 3'($urandom);
        b_ctrl_d = 16'($urandom); b_valid_d = 1'($urandom);
        b_stall  = 3'($urandom);  b_flush   = 3'($urandom);
    endtask

    task automatic push_all_zero(input int c, input bit d, input string n);
        for (int s = 0; s < 3; s++) sb_push(c, d, K_CTRL, s, 16'h0, n);
        sb_push(c, d, K_VALID, 0, 16'h0, n);
        sb_push(c, d, K_REQ, 0, 16'h0, n);
        sb_push(c, d, K_BUSY, 0, 16'h0, n);
    endtask

    initial begin
        rst = 1'b0;
        rand_inputs();
        for (int c = 1; c <= 2; c++) begin
            push_all_zero(c, 1'b0, "reset_a");
            push_all_zero(c, 1'b1, "reset_b");
        end
        goto(1);
        rand_inputs();
        goto(2);
        rst = 1'b1;
        a_ctrl_d = 16'hA5A5; a_valid_d = 1'b1; a_stall = '0; a_flush = '0;
        b_ctrl_d = 16'h0;    b_valid_d = 1'b0; b_stall = '0; b_flush = '0;
        sb_push(3, 0, K_CTRL, 0, 16'hA5A5, "lat_s0");
        sb_push(5, 0, K_CTRL, 2, 16'hA5A5, "lat_s2");
        sb_push(5, 0, K_VALID, 0, 16'h0007, "lat_valid");

        // Bubble behind a stage-0 stall
        goto(5);
        n_total++;
        if (a_ctrl_q[47:32] === 16'hA5A5 && a_valid_q === 3'b111) n_pass++;
        else $display("FAIL direct_lat cyc=%0d s2=%h valid=%b", cyc, a_ctrl_q[47:32], a_valid_q);
        a_ctrl_d = 16'h0011; a_stall = 3'b001;
        sb_push(6, 0, K_CTRL, 0, 16'hA5A5, "bub_hold_s0");
        sb_push(6, 0, K_CTRL, 1, 16'hA500, "bub_s1");
        sb_push(6, 0, K_VALID, 0, 16'h0005, "bub_valid");
        goto(6);
        a_stall = 3'b000;
        sb_push(7, 0, K_CTRL, 0, 16'h0011, "bub_release_s0");
        sb_push(7, 0, K_VALID, 0, 16'h0003, "bub_release_valid");

        // Flush beats hold on stage 1
        goto(7);
        a_ctrl_d = 16'hFFFF; a_valid_d = 1'b0;
        sb_push(8, 0, K_CTRL, 0, 16'hFFFF, "fl_pre_s0");
        sb_push(8, 0, K_VALID, 0, 16'h0006, "fl_pre_valid");
        goto(8);
        a_ctrl_d = 16'h0; a_stall = 3'b010; a_flush = 3'b010;
        sb_push(9, 0, K_CTRL, 1, 16'hFF00, "flush_over_hold");
        sb_push(9, 0, K_CTRL, 2, 16'h0000, "flush_bubble_s2");
        sb_push(9, 0, K_VALID, 0, 16'h0000, "flush_valid");

        // Four-cycle multi-cycle entry, arrives in stage 0 at cycle 10
        goto(9);
        a_stall = '0; a_flush = '0; a_ctrl_d = 16'h4123; a_valid_d = 1'b1;
        sb_push(10, 0, K_REQ, 0, 16'h1, "mc_req_t0");
        sb_push(10, 0, K_BUSY, 0, 16'h0, "mc_busy_t0");
        sb_push(11, 0, K_REQ, 0, 16'h1, "mc_req_t1");
        sb_push(11, 0, K_BUSY, 0, 16'h1, "mc_busy_t1");
        sb_push(11, 0, K_CTRL, 1, 16'h4100, "mc_bubble_t1");
        sb_push(12, 0, K_REQ, 0, 16'h1, "mc_req_t2");
        sb_push(13, 0, K_REQ, 0, 16'h0, "mc_req_t3");
        sb_push(13, 0, K_BUSY, 0, 16'h1, "mc_busy_done");
        sb_push(13, 0, K_CTRL, 0, 16'h4123, "mc_held_t3");
        sb_push(13, 0, K_CTRL, 1, 16'h4100, "mc_bubble_t3");
        sb_push(14, 0, K_REQ, 0, 16'h0, "mc_req_t4");
        sb_push(14, 0, K_BUSY, 0, 16'h0, "mc_busy_t4");
        sb_push(14, 0, K_CTRL, 1, 16'h4123, "mc_leave_s1");
        sb_push(14, 0, K_CTRL, 0, 16'h0002, "mc_next_s0");
        sb_push(14, 0, K_VALID, 0, 16'h0003, "mc_valid_t4");
        goto(10);
        a_ctrl_d = 16'h0002;

        goto(13);
        n_total++;
        if (a_req === 1'b0 && a_ctrl_q[15:0] === 16'h4123) n_pass++;
        else $display("FAIL direct_mc_done cyc=%0d req=%b s0=%h", cyc, a_req, a_ctrl_q[15:0]);

        // Abort in BUSY by flushing stage 0
        goto(14);
        n_total++;
        if (a_ctrl_q[31:16] === 16'h4123) n_pass++;
        else $display("FAIL direct_mc_leave cyc=%0d s1=%h", cyc, a_ctrl_q[31:16]);
        a_ctrl_d = 16'h4456;
        sb_push(15, 0, K_REQ, 0, 16'h1, "ab_req_t0");
        sb_push(16, 0, K_BUSY, 0, 16'h1, "ab_busy_busy");
        sb_push(16, 0, K_REQ, 0, 16'h1, "ab_req_busy");
        sb_push(17, 0, K_BUSY, 0, 16'h0, "ab_busy_after");
        sb_push(17, 0, K_REQ, 0, 16'h0, "ab_req_after");
        sb_push(17, 0, K_VALID, 0, 16'h0000, "ab_valid_after");
        sb_push(17, 0, K_CTRL, 0, 16'h0000, "ab_ctrl_s0");
        goto(15);
        a_ctrl_d = 16'h0; a_valid_d = 1'b0;
        goto(16);
        a_flush = 3'b001;

        // Reset while the sequencer is busy
        goto(17);
        a_flush = '0; a_ctrl_d = 16'h4789; a_valid_d = 1'b1;
        sb_push(18, 0, K_REQ, 0, 16'h1, "rs_req");
        sb_push(19, 0, K_BUSY, 0, 16'h1, "rs_busy");
        push_all_zero(20, 1'b0, "rs_mid");
        goto(18);
        a_ctrl_d = 16'h0; a_valid_d = 1'b0;
        goto(19);
        rst = 1'b0;
        goto(20);
        rst = 1'b1;

        // Two-cycle entry with external stall held through DONE
        goto(21);
        b_ctrl_d = 16'h4ABC; b_valid_d = 1'b1;
        sb_push(22, 1, K_REQ, 0, 16'h1, "d2_req_t0");
        sb_push(22, 1, K_BUSY, 0, 16'h0, "d2_busy_t0");
        sb_push(22, 1, K_CTRL, 0, 16'h4ABC, "d2_s0_t0");
        for (int c = 23; c <= 26; c++) begin
            sb_push(c, 1, K_REQ, 0, 16'h0, "d2_req_done");
            sb_push(c, 1, K_BUSY, 0, 16'h1, "d2_busy_done");
        end
        sb_push(26, 1, K_CTRL, 0, 16'h4ABC, "d2_held_s0");
        sb_push(26, 1, K_CTRL, 1, 16'h4A00, "d2_bubble_s1");
        sb_push(27, 1, K_BUSY, 0, 16'h0, "d2_idle");
        sb_push(27, 1, K_REQ, 0, 16'h0, "d2_no_retrigger");
        sb_push(27, 1, K_CTRL, 1, 16'h4ABC, "d2_leave_s1");
        sb_push(27, 1, K_CTRL, 0, 16'h0003, "d2_next_s0");
        goto(22);
        b_ctrl_d = 16'h0003;
        goto(23);
        b_stall = 3'b001;
        goto(26);
        b_stall = 3'b000;
        goto(27);
        b_valid_d = 1'b0;

        goto(30);
        @(negedge clk);
        #1;
        foreach (sb[i]) begin
            n_total++;
            $display("FAIL %s dut=%0d never_checked due_cyc=%0d exp=%h",
                     sb[i].name, sb[i].dut, sb[i].cyc, sb[i].exp);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Parametrised control-word pipeline that carries decoded control bits from decode through `STAGES` downstream stages, with per-stage stall/flush, per-bit flush masking, automatic bubble insertion and a built-in multi-cycle occupancy sequencer for long-latency operations such as mul/div. It sits between the main decoder and the datapath. It replaces the hand-instantiated per-signal stage registers with one block whose valid bits and stall-request output the hazard unit consumes directly.

## Interface
- `WIDTH`, default 16: control-word width in bits.
- `STAGES`, default 3: number of stages. Index 0 is E, 1 is M, 2 is W.
- `CLR_MASK`, default all ones (WIDTH bits): bit set means the field is zeroed on flush or bubble; bit clear means the field always loads from upstream.
- `MC_BIT`, default 0: index of the control bit that marks a multi-cycle op.
- `MC_STAGE`, default 0: stage whose entry the sequencer holds.
- `MC_CYCLES`, default 4: total occupancy of a multi-cycle entry in `MC_STAGE`. Legal range is 2 to 64.
- `clk`, in, 1: rising-edge clock.
- `rst`, in, 1: synchronous reset, active-low.
- `ctrl_d`, in, WIDTH: control word from decode.
- `valid_d`, in, 1: decode-stage instruction valid.
- `stall`, in, STAGES: per-stage external hold. Bit i holds stage i.
- `flush`, in, STAGES: per-stage clear.
- `ctrl_q`, out, STAGES*WIDTH: stage i word is at bits [i*WIDTH +: WIDTH].
- `valid_q`, out, STAGES: per-stage valid.
- `mc_stall_req`, out, 1: request to the hazard unit to hold decode and all stages up to `MC_STAGE`.
- `mc_busy`, out, 1: sequencer is not in IDLE.

## Operation
- Reset (`rst`=0 at an edge): every output is 0. `ctrl_q`=0, `valid_q`=0, `mc_stall_req`=0, `mc_busy`=0. Sequencer goes to IDLE with the counter at 0.
- Effective hold: `hold[i] = stall[i] | (mc_stall_req & i<=MC_STAGE)`.
- Upstream of stage 0 is `ctrl_d`/`valid_d`, with upstream hold taken as 0. Upstream of stage i>0 is stage i-1.
- Per-stage update priority, highest first:
  1. `flush[i]`: valid becomes 0. Masked bits become 0. Unmasked bits load from upstream. Flush beats hold.
  2. `hold[i]`: the stage keeps its contents.
  3. `hold[i-1]` (i>0): bubble. Valid becomes 0, masked bits 0, unmasked bits load from upstream.
  4. Otherwise the stage loads its upstream word and valid.
- Trigger: `valid_q[MC_STAGE] & ctrl_q[MC_STAGE][MC_BIT]` while the sequencer is in IDLE.
- Sequencer FSM:
  - IDLE: on trigger, `mc_stall_req`=1. If `MC_CYCLES`==2, go to DONE. Otherwise go to BUSY with cnt = `MC_CYCLES`-3.
  - BUSY: `mc_stall_req`=1. When cnt==0, go to DONE; otherwise decrement cnt.
  - DONE: `mc_stall_req`=0. Stay in DONE while `hold[MC_STAGE]`. Go to IDLE on the edge where the stage loads, so the same entry never retriggers.
  - `flush[MC_STAGE]` in any state: go to IDLE with cnt=0. This takes priority over every other transition.
- `mc_stall_req` is a function of registered state and stage contents only. It never depends combinationally on `stall` or `flush`, so no loop exists through the hazard unit.
- `mc_busy` is 1 when state is BUSY or DONE.
- Counter width is `$clog2(MC_CYCLES)`. The counter never wraps.

## Timing
- Latency: a word presented at `ctrl_d` with no holds appears in stage i after i+1 edges.
- Multi-cycle entry arriving in `MC_STAGE` at cycle T:
  - `mc_stall_req` is high T to T+`MC_CYCLES`-2.
  - The entry leaves on the edge ending cycle T+`MC_CYCLES`-1, absent external stall.
- An external stall during DONE extends occupancy without reasserting `mc_stall_req`.
- Reset mid-operation aborts the sequencer immediately. The next cycle shows all outputs at 0.
- Flush and hold asserted on the same stage in the same cycle: flush wins.

## Structure
- Package `ctrl_pipe_pkg` holds:
  - The `mc_state_t` enum: IDLE, BUSY, DONE.
  - The counter-width helper.
  - The default E/M/W stage-index constants.
- Sub-module `ctrl_pipe_stage`: one WIDTH-bit register with a valid bit and the priority chain. It takes the clear mask as a parameter and the upstream hold as a port.
- The top level contains a generate loop over `ctrl_pipe_stage` plus the sequencer.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with random inputs -> all outputs 0. After release, `ctrl_d`=16'hA5A5 with valid, no holds -> stage 2 shows A5A5 with valid=1 after the third edge.
- Bubble: assert `stall[0]` for 1 cycle with `ctrl_d`=16'h0011 -> stage 0 holds. Stage 1 gets valid=0, with masked bits 0 and unmasked bits equal to the stage-0 word.
- Flush over hold: `CLR_MASK`=16'h00FF, `stall[1]`=`flush[1]`=1, stage-0 word 16'hFFFF -> stage 1 = 16'hFF00, valid 0.
- Multi-cycle: `MC_CYCLES`=4, MC entry reaches stage 0 at T -> `mc_stall_req` high for exactly T, T+1, T+2. The entry is in stage 1 at T+4. Stage 1 shows bubbles at T+1 to T+3.
- Abort: MC entry in BUSY with `flush[0]` asserted -> next cycle `mc_busy`=0, `mc_stall_req`=0, `valid_q[0]`=0.
- DONE hold: `MC_CYCLES`=2 with `stall[0]` held 3 cycles after DONE -> `mc_stall_req` stays 0, no retrigger, the entry advances once the stall drops.
